instr_encoder: RTL and testbench

- Builds 32-bit RV32I instruction words from decoded fields. It is the inverse of the main/ALU decode path.
- Streams the encoded words into instruction memory through a write port at sequential word addresses.
- Used by the self-loading test harness and the boot loader to place programs in imem without external hex files.
- Covers exactly the instruction classes the control path decodes: lw, sw, R-type, beq, I-type ALU, jal.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/instr_pack.sv | 78 +++++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared RV32I encoding definitions used by the instruction encoder and by
//   the main decoder.
//   - instr_kind_e : the instruction classes the control path understands
//   - OP_*         : 7-bit major opcodes (instruction bits [6:0])
//   - F3_*         : fixed funct3 values for the formats that hard-wire them
//   - IMM_*        : legal immediate ranges of each format, in bytes
//   - in_range()   : signed range test of a 32-bit immediate
package riscv_pkg;

   typedef enum logic [2:0] {
      KIND_LW    = 3'd0,
      KIND_SW    = 3'd1,
      KIND_RTYPE = 3'd2,
      KIND_BEQ   = 3'd3,
      KIND_IALU  = 3'd4,
      KIND_JAL   = 3'd5
   } instr_kind_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_WORD   = 3'b010;  // lw / sw access width
   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;  // slli
   localparam logic [2:0] F3_SRX    = 3'b101;  // srli / srai

   // Immediate ranges (inclusive). B and J offsets must also be even.
   localparam int IMM_I_MIN = -2048;
   localparam int IMM_I_MAX = 2047;
   localparam int SHAMT_MIN = 0;
   localparam int SHAMT_MAX = 31;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;
   localparam int IMM_J_MIN = -1048576;
   localparam int IMM_J_MAX = 1048574;

   // Byte stride between consecutive instruction words.
   localparam int WORD_BYTES = 4;

   function automatic logic in_range(input logic [31:0] value,
                                     input int lo,
                                     input int hi);
      return ($signed(value) >= lo) && ($signed(value) <= hi);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack
//   Purely combinational: turns one decoded field bundle into the 32-bit
//   RV32I instruction word and flags bundles that cannot be encoded.
//   Ports:
//     kind      : instruction class (instr_kind_e encoding, 6/7 illegal)
//     funct3    : R-type / I-type ALU operation select
//     funct7b5  : sub/sra (R-type) and srai (I-type shift) select
//     rd,rs1,rs2: register indices; fields a format does not use are ignored
//     imm       : signed immediate / byte offset
//     word      : encoded instruction, forced to zero when illegal
//     illegal   : bundle is not encodable (bad kind or immediate)
import riscv_pkg::*;

module instr_pack (
   input  logic [2:0]  kind,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   instr_kind_e k;
   logic        is_shift;

   assign k        = instr_kind_e'(kind);
   // slli/srli/srai carry a 5-bit shamt plus funct7 in the immediate slot.
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (k)
         KIND_LW: begin
            word    = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
            illegal = ~in_range(imm, IMM_I_MIN, IMM_I_MAX);
         end
         KIND_SW: begin
            word    = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
            illegal = ~in_range(imm, IMM_I_MIN, IMM_I_MAX);
         end
         KIND_RTYPE: begin
            word    = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
            illegal = 1'b0;
         end
         KIND_BEQ: begin
            word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11],
                       OP_BRANCH};
            illegal = ~in_range(imm, IMM_B_MIN, IMM_B_MAX) | imm[0];
         end
         KIND_IALU: begin
            if (is_shift) begin
               word    = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd,
                          OP_IALU};
               illegal = ~in_range(imm, SHAMT_MIN, SHAMT_MAX);
            end else begin
               word    = {imm[11:0], rs1, funct3, rd, OP_IALU};
               illegal = ~in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
         end
         KIND_JAL: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            illegal = ~in_range(imm, IMM_J_MIN, IMM_J_MAX) | imm[0];
         end
         default: begin
            word    = '0;
            illegal = 1'b1;
         end
      endcase
      if (illegal) begin
         word = '0;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes decoded RV32I field bundles and streams the words into
//   instruction memory at consecutive word addresses starting at BASE.
//
//   Handshakes (both sides): a transfer happens at a rising clk edge where
//   valid and ready are both 1. A producer holds valid and its payload
//   stable until the transfer; ready never depends on the same side's
//   valid. in_ready additionally never depends on out_ready.
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (dominates clear)
//     clear        : synchronous flush of FIFO, address and err
//     in_valid/in_ready + in_* fields : field bundle input
//     out_valid/out_ready, out_addr, out_data : imem write port
//     err          : sticky, a bundle was accepted but could not be encoded
//
//   Parameters:
//     AW   : width of out_addr
//     BASE : byte address of the first word (4-aligned)
import riscv_pkg::*;

module instr_encoder #(
   parameter int          AW   = 32,
   parameter logic [31:0] BASE = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_kind,
   input  logic [2:0]    in_funct3,
   input  logic          in_funct7b5,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs1,
   input  logic [4:0]    in_rs2,
   input  logic [31:0]   in_imm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [31:0]   out_data,
   output logic          err
);

   localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
   localparam logic [AW-1:0] STRIDE    = AW'(WORD_BYTES);

   logic [31:0]   pack_word;
   logic          pack_illegal;

   logic [31:0]   fifo_mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic [AW-1:0] addr_q;
   logic          err_q;

   logic          accept;
   logic          push;
   logic          pop;

   instr_pack u_pack (
      .kind     (in_kind),
      .funct3   (in_funct3),
      .funct7b5 (in_funct7b5),
      .rd       (in_rd),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .imm      (in_imm),
      .word     (pack_word),
      .illegal  (pack_illegal)
   );

   assign in_ready  = (count < 2'd2) & ~clear;
   assign out_valid = (count != 2'd0);
   // Illegal bundles are still handshaken so the producer never stalls on
   // them; they simply never reach the FIFO.
   assign accept    = in_valid & in_ready;
   assign push      = accept & ~pack_illegal;
   // A pop coinciding with clear is discarded together with the FIFO.
   assign pop       = out_valid & out_ready & ~clear;

   // The address is attached at pop time, so dropped bundles leave no gap.
   assign out_addr  = addr_q;
   assign out_data  = out_valid ? fifo_mem[rd_ptr] : 32'h0;
   assign err       = err_q;

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= pack_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         addr_q <= BASE_ADDR;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            addr_q <= addr_q + STRIDE;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (accept && pack_illegal) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   localparam int          AW   = 32;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic          clk;
   logic          reset;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_kind;
   logic [2:0]    in_funct3;
   logic          in_funct7b5;
   logic [4:0]    in_rd;
   logic [4:0]    in_rs1;
   logic [4:0]    in_rs2;
   logic [31:0]   in_imm;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [31:0]   out_data;
   logic          err;

   instr_encoder #(.AW(AW), .BASE(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_kind     (in_kind),
      .in_funct3   (in_funct3),
      .in_funct7b5 (in_funct7b5),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .err         (err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- counters / scoreboard state ----------------
   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_addr = BASE;
   logic        exp_err  = 1'b0;

   bit          tbl_mode = 1'b1;
   logic [31:0] cur_word = '0;
   bit          cur_ill  = 1'b0;

   bit          have_prev = 1'b0;
   logic [31:0] prev_data;
   logic [31:0] prev_addr;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Places each field at its bit position with plain arithmetic.
   function automatic void ref_encode(input logic [2:0] kind, input logic [2:0] f3,
                                      input logic f7b5, input logic [4:0] rd_i,
                                      input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                                      input logic [31:0] imm,
                                      output logic [31:0] w, output bit ill);
      int unsigned u, rd, rs1, rs2, fn3, b5;
      int          s;
      u = imm; s = $signed(imm);
      rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; fn3 = f3; b5 = f7b5;
      w = 0; ill = 0;
      case (kind)
         3'd0: begin
            ill = (s < -2048) || (s > 2047);
            w = 3 + rd*128 + 2*4096 + rs1*32768 + (u % 4096) * 1048576;
         end
         3'd1: begin
            ill = (s < -2048) || (s > 2047);
            w = 35 + (u % 32)*128 + 2*4096 + rs1*32768 + rs2*1048576
                + ((u / 32) % 128) * 33554432;
         end
         3'd2: begin
            w = 51 + rd*128 + fn3*4096 + rs1*32768 + rs2*1048576 + b5*1073741824;
         end
         3'd3: begin
            ill = (s < -4096) || (s > 4094) || (u % 2 != 0);
            w = 99 + ((u / 2048) % 2)*128 + ((u / 2) % 16)*256 + rs1*32768
                + rs2*1048576 + ((u / 32) % 64)*33554432
                + ((u / 4096) % 2)*32'h8000_0000;
         end
         3'd4: begin
            if (fn3 == 1 || fn3 == 5) begin
               ill = (s < 0) || (s > 31);
               w = 19 + rd*128 + fn3*4096 + rs1*32768 + (u % 32)*1048576
                   + b5*1073741824;
            end else begin
               ill = (s < -2048) || (s > 2047);
               w = 19 + rd*128 + fn3*4096 + rs1*32768 + (u % 4096)*1048576;
            end
         end
         3'd5: begin
            ill = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
            w = 111 + rd*128 + ((u / 4096) % 256)*4096 + ((u / 2048) % 2)*1048576
                + ((u / 2) % 1024)*2097152 + ((u / 1048576) % 2)*32'h8000_0000;
         end
         default: ill = 1;
      endcase
   endfunction

   // ---------------- monitor / scoreboard (negedge sampling) ----------------
   always @(negedge clk) begin
      logic [31:0] w;
      bit          ill;
      if (reset) begin
         exp_q.delete();
         exp_addr  = BASE;
         exp_err   = 1'b0;
         have_prev = 1'b0;
      end else begin
         check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2) && !clear});
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
         check("err", {31'b0, err}, {31'b0, exp_err});
         if (have_prev) begin
            check("hold_data", out_data, prev_data);
            check("hold_addr", out_addr, prev_addr);
         end
         have_prev = (exp_q.size() != 0) && !out_ready && !clear;
         prev_data = out_data;
         prev_addr = out_addr;
         if (clear) begin
            exp_q.delete();
            exp_addr = BASE;
            exp_err  = 1'b0;
         end else begin
            if (exp_q.size() != 0 && out_ready) begin
               check("out_data", out_data, exp_q.pop_front());
               check("out_addr", out_addr, exp_addr);
               exp_addr = exp_addr + 32'd4;
            end
            if (in_valid && in_ready) begin
               if (tbl_mode) begin
                  w = cur_word; ill = cur_ill;
               end else begin
                  ref_encode(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1,
                             in_rs2, in_imm, w, ill);
               end
               if (ill) exp_err = 1'b1;
               else     exp_q.push_back(w);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   typedef struct {
      logic [2:0]  kind;
      logic [2:0]  f3;
      logic        f7b5;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] word;
      bit          ill;
   } vec_t;

   function automatic vec_t mk(input int kind, input int f3, input int f7b5,
                               input int rd, input int rs1, input int rs2,
                               input int imm, input logic [31:0] word, input bit ill);
      vec_t v;
      v.kind = 3'(kind); v.f3 = 3'(f3); v.f7b5 = 1'(f7b5);
      v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.imm = 32'(imm); v.word = word; v.ill = ill;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      in_kind = v.kind; in_funct3 = v.f3; in_funct7b5 = v.f7b5;
      in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
      cur_word = v.word; cur_ill = v.ill;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: in_ready stayed low for 50 cycles, expected accept", name);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input vec_t v, input string name);
      apply(v);
      wait_accept(name);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
      idle(1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d words never emitted, expected 0", name, exp_q.size());
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   vec_t tbl[$];

   initial begin
      vec_t a, b, c, d;
      int   r;
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_kind = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

      // kind f3 f7b5 rd rs1 rs2 imm word ill
      tbl.push_back(mk(4, 0, 0, 5, 0, 0, 10, 32'h00A00293, 0));
      tbl.push_back(mk(0, 0, 0, 2, 1, 7, 8, 32'h0080A103, 0));
      tbl.push_back(mk(1, 0, 0, 9, 1, 2, 4, 32'h0020A223, 0));
      tbl.push_back(mk(4, 0, 0, 1, 0, 0, 2048, 32'h0, 1));
      tbl.push_back(mk(3, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 0));
      tbl.push_back(mk(3, 0, 0, 0, 1, 2, 3, 32'h0, 1));
      tbl.push_back(mk(5, 0, 0, 1, 31, 31, 8, 32'h008000EF, 0));
      tbl.push_back(mk(7, 0, 0, 1, 1, 1, 0, 32'h0, 1));
      tbl.push_back(mk(2, 0, 0, 3, 1, 2, 0, 32'h002081B3, 0));
      tbl.push_back(mk(2, 0, 1, 3, 1, 2, 0, 32'h402081B3, 0));
      tbl.push_back(mk(4, 5, 1, 1, 2, 0, 3, 32'h40315093, 0));
      tbl.push_back(mk(4, 1, 0, 3, 4, 0, 31, 32'h01F21193, 0));
      tbl.push_back(mk(4, 1, 0, 3, 4, 0, 32, 32'h0, 1));
      tbl.push_back(mk(4, 5, 0, 3, 4, 0, -1, 32'h0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, -2048, 32'h80002083, 0));
      tbl.push_back(mk(4, 0, 0, 1, 0, 0, 2047, 32'h7FF00093, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, -2049, 32'h0, 1));
      tbl.push_back(mk(3, 0, 0, 0, 0, 0, 4094, 32'h7E000FE3, 0));
      tbl.push_back(mk(3, 0, 0, 0, 0, 0, 4096, 32'h0, 1));
      tbl.push_back(mk(5, 0, 0, 0, 0, 0, 1048574, 32'h7FFFF06F, 0));
      tbl.push_back(mk(5, 0, 0, 0, 0, 0, -1048576, 32'h8000006F, 0));
      tbl.push_back(mk(5, 0, 0, 0, 0, 0, 1048576, 32'h0, 1));
      tbl.push_back(mk(5, 0, 0, 0, 0, 0, 7, 32'h0, 1));
      tbl.push_back(mk(6, 0, 0, 0, 0, 0, 0, 32'h0, 1));

      idle(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_addr", out_addr, BASE);
      check("rst_err", {31'b0, err}, 32'd0);
      @(posedge clk); #1;

      // Table: one bundle at a time with the sink always ready.
      tbl_mode = 1'b1;
      out_ready = 1'b1;
      foreach (tbl[i]) send(tbl[i], $sformatf("tbl%0d", i));
      drain("tbl_drain");
      pulse_clear();

      // Sink stalled while three bundles are offered.
      out_ready = 1'b0;
      send(tbl[1], "stall_a");
      send(tbl[2], "stall_b");
      apply(tbl[4]);
      idle(3);
      out_ready = 1'b1;
      wait_accept("stall_c");
      drain("stall_drain");

      // Clear with two queued words and err set; offered bundle and pop ignored.
      out_ready = 1'b0;
      send(tbl[7], "clr_ill");
      send(tbl[8], "clr_a");
      send(tbl[9], "clr_b");
      apply(tbl[10]);
      clear = 1'b1;
      out_ready = 1'b1;
      idle(1);
      clear = 1'b0;
      in_valid = 1'b0;
      send(tbl[0], "clr_next");
      drain("clr_drain");

      // Reset in the middle of a stream behaves like clear.
      out_ready = 1'b0;
      send(tbl[3], "rst_ill");
      send(tbl[8], "rst_a");
      send(tbl[9], "rst_b");
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_err", {31'b0, err}, 32'd0);
      check("midrst_out_addr", out_addr, BASE);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(tbl[0], "rst_next");
      drain("rst_drain");

      // Randomised traffic against the reference model.
      tbl_mode = 1'b0;
      a = tbl[0]; b = a; c = a; d = a;
      for (int i = 0; i < 500; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         clear       = ($urandom_range(0, 49) == 0);
         in_kind     = 3'($urandom_range(0, 7));
         in_funct3   = 3'($urandom_range(0, 7));
         in_funct7b5 = 1'($urandom_range(0, 1));
         in_rd       = 5'($urandom);
         in_rs1      = 5'($urandom);
         in_rs2      = 5'($urandom);
         case ($urandom_range(0, 5))
            0: r = int'($urandom_range(0, 4095)) - 2048;
            1: r = int'($urandom_range(0, 63)) - 16;
            2: r = int'($urandom_range(0, 8199)) - 4100;
            3: r = int'($urandom_range(0, 2097155)) - 1048578;
            4: r = int'($urandom_range(0, 64)) - 32;
            default: r = int'($urandom);
         endcase
         in_imm = 32'(r);
         idle(1);
      end
      in_valid = 1'b0;
      clear = 1'b0;
      out_ready = 1'b1;
      drain("rand_drain");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
